// File: rtl/dimm_cmd_scheduler.sv
// dimm_cmd_scheduler: in-order closed-page DDR5 ACT/CAS/PRE command scheduler.
// Optional macro DIMM_RD_DATA_WAIT_EN: read PRE waits for the read burst to end.
module dimm_cmd_scheduler #(
  parameter int QDEPTH  = 16,
  parameter int T_RP    = 39,
  parameter int T_RCD   = 39,
  parameter int T_CL    = 40,
  parameter int T_BURST = 8,
  parameter int T_RTP   = 18,
  parameter int T_WR    = 30,
  parameter int T_CWL   = 38,
  parameter int T_RC    = 115
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_op,
  input  logic [35:0]                 req_addr,
  output logic                        err_illegal,
  output logic                        cmd_valid,
  output logic [2:0]                  cmd_type,
  output logic                        cmd_ch,
  output logic [2:0]                  cmd_bg,
  output logic [1:0]                  cmd_ba,
  output logic [15:0]                 cmd_addr,
  output logic                        rsp_valid,
  output logic [1:0]                  rsp_op,
  output logic [$clog2(QDEPTH+1)-1:0] q_count,
  output logic                        busy
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int TMAX = (T_RC > T_RP) ? T_RC : T_RP;
  localparam int TW = $clog2(TMAX + 1);
  // CAS-to-PRE gaps; burst-based data timing counts from the second CAS cycle
  localparam int WR_GAP = 1 + T_CWL + T_BURST + T_WR;
`ifdef DIMM_RD_DATA_WAIT_EN
  localparam int RD_GAP = 1 + T_CL + T_BURST;
`else
  localparam int RD_GAP = T_RTP;
`endif
  localparam int G1 = (RD_GAP > WR_GAP) ? RD_GAP : WR_GAP;
  localparam int WMAX = (G1 > T_RCD) ? G1 : T_RCD;
  localparam int WW = $clog2(WMAX + 1);

  localparam logic [2:0] C_ACT0 = 3'd0;
  localparam logic [2:0] C_ACT1 = 3'd1;
  localparam logic [2:0] C_RD0  = 3'd2;
  localparam logic [2:0] C_WR0  = 3'd4;
  localparam logic [2:0] C_PRE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_PRE, PRE
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic        ch;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
  } entry_t;

  state_t state, state_n;
  entry_t q [QDEPTH];
  entry_t head, ent, new_ent;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nx, wr_nx;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] rp [32];
  logic [TW-1:0] rc [32];
  logic [4:0] ent_bank;
  logic legal, take, push, pop, have, cand_ok, is_wr;
  logic is_act, is_cas, is_pre;
  logic unused_bits;

  assign unused_bits = ^{req_addr[35:34], req_addr[1:0]};

  assign legal = (req_op != 2'd3) && !req_addr[6];
  assign take  = req_valid && req_ready;
  assign push  = take && legal;
  assign pop   = (state == PRE);

  assign rd_nx = (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
  assign wr_nx = (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;

  // In PRE the head is leaving, so the next candidate is the entry behind it
  assign head     = q[rd_ptr];
  assign ent      = (state == PRE) ? q[rd_nx] : head;
  assign ent_bank = {ent.bg, ent.ba};
  assign is_wr    = (head.op == 2'd1);

  assign have = (state == PRE) ? (cnt > CW'(1)) : (cnt != '0);
  // A timer at 1 reaches 0 on the same edge the ACT0 is registered
  assign cand_ok = have && (rp[ent_bank] < TW'(2)) &&
                   (rc[ent_bank] < TW'(2));

  assign new_ent.op  = req_op;
  assign new_ent.ch  = req_addr[6];
  assign new_ent.bg  = req_addr[9:7];
  assign new_ent.ba  = req_addr[11:10];
  assign new_ent.row = req_addr[33:18];
  assign new_ent.col = {req_addr[17:12], req_addr[5:2]};

  assign req_ready = (cnt < CW'(QDEPTH));
  assign q_count   = cnt;
  assign busy      = (cnt != '0) || (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (cand_ok) state_n = ACT0;
      ACT0:     state_n = ACT1;
      ACT1:     state_n = WAIT_RCD;
      WAIT_RCD: if (wcnt == '0) state_n = CAS0;
      CAS0:     state_n = CAS1;
      CAS1:     state_n = WAIT_PRE;
      WAIT_PRE: if (wcnt == '0) state_n = PRE;
      PRE:      state_n = cand_ok ? ACT0 : IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign is_act = (state_n == ACT0) || (state_n == ACT1);
  assign is_cas = (state_n == CAS0) || (state_n == CAS1);
  assign is_pre = (state_n == PRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else begin
      unique case (state)
        ACT1:     wcnt <= WW'(T_RCD - 3);
        CAS1:     wcnt <= is_wr ? WW'(WR_GAP - 3) : WW'(RD_GAP - 3);
        WAIT_RCD,
        WAIT_PRE: if (wcnt != '0) wcnt <= wcnt - 1'b1;
        default:  wcnt <= wcnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_nx;
      if (pop)  rd_ptr <= rd_nx;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= new_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rp[i] <= '0;
        rc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (rp[i] != '0) rp[i] <= rp[i] - 1'b1;
        if (rc[i] != '0) rc[i] <= rc[i] - 1'b1;
      end
      if (state_n == ACT0) rc[ent_bank] <= TW'(T_RC);
      if (state_n == PRE)  rp[ent_bank] <= TW'(T_RP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_type    <= '0;
      cmd_ch      <= 1'b0;
      cmd_bg      <= '0;
      cmd_ba      <= '0;
      cmd_addr    <= '0;
      rsp_valid   <= 1'b0;
      rsp_op      <= '0;
    end else begin
      err_illegal <= take && !legal;
      cmd_valid   <= 1'b0;
      rsp_valid   <= 1'b0;
      if (is_act || is_cas || is_pre) begin
        cmd_ch <= ent.ch;
        cmd_bg <= ent.bg;
        cmd_ba <= ent.ba;
      end
      unique case (1'b1)
        is_act: begin
          cmd_valid <= 1'b1;
          cmd_type  <= (state_n == ACT0) ? C_ACT0 : C_ACT1;
          cmd_addr  <= ent.row;
        end
        is_cas: begin
          cmd_valid <= 1'b1;
          cmd_type  <= (is_wr ? C_WR0 : C_RD0) |
                       {2'b00, state_n == CAS1};
          cmd_addr  <= {6'd0, ent.col};
        end
        is_pre: begin
          cmd_valid <= 1'b1;
          cmd_type  <= C_PRE;
          cmd_addr  <= '0;
          rsp_valid <= 1'b1;
          rsp_op    <= ent.op;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dimm_cmd_scheduler.sv
// tb_dimm_cmd_scheduler: scoreboard bench with a per-request timing model.
// Honours DIMM_RD_DATA_WAIT_EN for the read CAS-to-PRE gap.
module tb_dimm_cmd_scheduler;

  localparam int QDEPTH  = 16;
  localparam int T_RP    = 39;
  localparam int T_RCD   = 39;
  localparam int T_CL    = 40;
  localparam int T_BURST = 8;
  localparam int T_RTP   = 18;
  localparam int T_WR    = 30;
  localparam int T_CWL   = 38;
  localparam int T_RC    = 115;
`ifdef DIMM_RD_DATA_WAIT_EN
  localparam int RD_GAP = 1 + T_CL + T_BURST;
`else
  localparam int RD_GAP = T_RTP;
`endif
  localparam int WR_GAP = 1 + T_CWL + T_BURST + T_WR;
  localparam logic [35:0] A0 = 36'h0_0004_0400;

  bit          clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [35:0] req_addr;
  logic        err_illegal;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic        cmd_ch;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_addr;
  logic        rsp_valid;
  logic [1:0]  rsp_op;
  logic [4:0]  q_count;
  logic        busy;

  dimm_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .err_illegal(err_illegal),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_ch(cmd_ch), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
    .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op),
    .q_count(q_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int typ;
    int bg;
    int ba;
    int addr;
    int op;
  } exp_t;

  exp_t expq[$];
  int   errq[$];
  int   acc_l[$];
  int   pre_l[$];
  int   bank_act[32];
  int   bank_pre[32];
  int   last_pre;
  int   vectors;
  int   miscompares;
  bit   mon_en;

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  function automatic int mcount(int k);
    int n;
    n = 0;
    foreach (acc_l[i]) if (acc_l[i] <= k && pre_l[i] >= k) n++;
    return n;
  endfunction

  task automatic model_reset();
    expq.delete();
    errq.delete();
    acc_l.delete();
    pre_l.delete();
    for (int i = 0; i < 32; i++) begin
      bank_act[i] = -1000;
      bank_pre[i] = -1000;
    end
    last_pre = -1000;
  endtask

  function automatic exp_t mk(int t, int typ, int bg, int ba, int a, int op);
    exp_t e;
    e.t = t; e.typ = typ; e.bg = bg; e.ba = ba; e.addr = a; e.op = op;
    return e;
  endfunction

  // Schedule a request accepted at edge e from the timing rules directly
  task automatic model_accept(int e, logic [1:0] op, logic [35:0] addr);
    int b, a, c, p, bg, ba, row, col, wr;
    if (op == 2'd3 || addr[6]) begin
      errq.push_back(e);
      return;
    end
    bg  = int'(addr[9:7]);
    ba  = int'(addr[11:10]);
    b   = bg * 4 + ba;
    row = int'(addr[33:18]);
    col = int'({addr[17:12], addr[5:2]});
    wr  = (op == 2'd1) ? 1 : 0;
    a = e + 1;
    if (last_pre + 1 > a)      a = last_pre + 1;
    if (bank_act[b] + T_RC > a) a = bank_act[b] + T_RC;
    if (bank_pre[b] + T_RP > a) a = bank_pre[b] + T_RP;
    c = a + T_RCD;
    p = c + (wr ? WR_GAP : RD_GAP);
    bank_act[b] = a;
    bank_pre[b] = p;
    last_pre    = p;
    acc_l.push_back(e);
    pre_l.push_back(p);
    expq.push_back(mk(a,     0, bg, ba, row, op));
    expq.push_back(mk(a + 1, 1, bg, ba, row, op));
    expq.push_back(mk(c,     wr ? 4 : 2, bg, ba, col, op));
    expq.push_back(mk(c + 1, wr ? 5 : 3, bg, ba, col, op));
    expq.push_back(mk(p,     6, bg, ba, 0, op));
  endtask

  int   m_k;
  bit   m_ee, m_ec;
  exp_t m_e;
  always @(negedge clk) begin
    if (mon_en) begin
      m_k = mcount(cyc);
      chk("q_count", q_count, m_k);
      chk("req_ready", req_ready, (m_k < QDEPTH) ? 1 : 0);
      chk("busy", busy, (m_k != 0) ? 1 : 0);
      m_ee = (errq.size() > 0) && (errq[0] == cyc);
      if (m_ee) void'(errq.pop_front());
      chk("err_illegal", err_illegal, m_ee);
      m_ec = (expq.size() > 0) && (expq[0].t == cyc);
      chk("cmd_valid", cmd_valid, m_ec);
      if (m_ec) begin
        m_e = expq.pop_front();
        if (cmd_valid) begin
          chk("cmd_type", cmd_type, m_e.typ);
          chk("cmd_ch", cmd_ch, 0);
          chk("cmd_bg", cmd_bg, m_e.bg);
          chk("cmd_ba", cmd_ba, m_e.ba);
          chk("cmd_addr", cmd_addr, m_e.addr);
          chk("rsp_valid", rsp_valid, (m_e.typ == 6) ? 1 : 0);
          if (m_e.typ == 6) chk("rsp_op", rsp_op, m_e.op);
        end
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send(logic [1:0] op, logic [35:0] addr);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    while (mcount(cyc) >= QDEPTH && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk("send_timeout", n, 0);
    end else begin
      model_accept(cyc + 1, op, addr);
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while ((expq.size() != 0 || mcount(cyc) != 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", (n < 6000) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_type"}, cmd_type, 0);
    chk({tag, "_cmd_addr"}, cmd_addr, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_err"}, err_illegal, 0);
    chk({tag, "_q_count"}, q_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  logic [63:0] rnd;
  logic [35:0] ra;
  logic [1:0]  rop;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // single read, single write, single ifetch
    send(2'd0, A0); drain();
    send(2'd1, A0); drain();
    send(2'd2, A0); drain();

    // same bank twice, then different bank groups
    send(2'd0, A0); send(2'd0, A0); drain();
    send(2'd0, A0); send(2'd0, A0 | 36'h80); drain();

    // illegal op, illegal channel bit
    send(2'd3, A0); send(2'd0, A0 | 36'h40); drain();

    // fill the queue past its depth
    for (int i = 0; i < 17; i++) begin
      ra = A0;
      ra[9:7] = 3'(i);
      send(2'd0, ra);
      if (i == 15) begin
        chk("q_full", q_count, 16);
        chk("ready_low", req_ready, 0);
      end
    end
    drain();

    // randomized traffic on a small bank set to force conflicts
    for (int i = 0; i < 50; i++) begin
      rnd = {$urandom, $urandom};
      ra  = rnd[35:0];
      ra[9:7]   = 3'($urandom_range(0, 1));
      ra[11:10] = 2'($urandom_range(0, 1));
      ra[6]     = ($urandom_range(0, 7) == 0);
      rop       = 2'($urandom_range(0, 3));
      send(rop, ra);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(20, 150));
      else idle($urandom_range(0, 3));
    end
    drain();

    // asynchronous reset in the middle of a read
    send(2'd0, A0);
    idle(20);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    send(2'd0, A0);
    drain();

    chk("expq_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
